// File: rtl/door_timer_fsm.sv
// Door sequencer: opens, holds and closes the car door on the upstream tick time base.
// door_closed is the interlock that allows car motion.
module door_timer_fsm #(
  parameter int unsigned TRAVEL_TICKS = 4,
  parameter int unsigned HOLD_TICKS   = 6,
  parameter int unsigned WIDTH        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       open_req,
  input  logic       close_req,
  input  logic       obstruct,
  output logic       motor_open,
  output logic       motor_close,
  output logic       door_closed,
  output logic       door_open,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    StClosed  = 2'd0,
    StOpening = 2'd1,
    StOpen    = 2'd2,
    StClosing = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] PosOpen  = WIDTH'(TRAVEL_TICKS);
  localparam logic [WIDTH-1:0] PosLast  = WIDTH'(TRAVEL_TICKS - 1);
  localparam logic [WIDTH-1:0] PosOne   = WIDTH'(1);
  localparam logic [WIDTH-1:0] HoldLast = WIDTH'(HOLD_TICKS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic [WIDTH-1:0] hold_q, hold_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StClosed;
      pos_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    hold_d  = hold_q;
    unique case (state_q)
      StClosed: begin
        if (open_req) begin
          state_d = StOpening;
        end
      end
      StOpening: begin
        if (tick) begin
          if (pos_q == PosLast) begin
            pos_d   = PosOpen;
            hold_d  = '0;
            state_d = StOpen;
          end else begin
            pos_d = pos_q + PosOne;
          end
        end
      end
      StOpen: begin
        // open_req and obstruct both restart the hold and mask close_req.
        if (open_req || obstruct) begin
          hold_d = '0;
        end else if (close_req) begin
          hold_d  = '0;
          state_d = StClosing;
        end else if (tick) begin
          if (hold_q == HoldLast) begin
            hold_d  = '0;
            state_d = StClosing;
          end else begin
            hold_d = hold_q + PosOne;
          end
        end
      end
      StClosing: begin
        // Reopen from the current position; a coincident tick is dropped.
        if (obstruct || open_req) begin
          state_d = StOpening;
        end else if (tick) begin
          if (pos_q == PosOne) begin
            pos_d   = '0;
            state_d = StClosed;
          end else begin
            pos_d = pos_q - PosOne;
          end
        end
      end
      default: begin
        state_d = StClosed;
      end
    endcase
  end

  assign motor_open  = (state_q == StOpening);
  assign motor_close = (state_q == StClosing);
  assign door_closed = (state_q == StClosed);
  assign door_open   = (state_q == StOpen);
  assign state       = state_q;

endmodule

// File: tb/tb_door_timer_fsm.sv
// Bench for door_timer_fsm: directed door sequences; a monitor checks each state
// transition against a queue of expected (state, ticks-since-last-transition) entries.
module tb_door_timer_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       open_req = 1'b0;
  logic       close_req = 1'b0;
  logic       obstruct = 1'b0;
  logic       motor_open, motor_close, door_closed, door_open;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int ticks_total = 0;

  typedef struct {
    logic [1:0] st;
    int         dticks;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  door_timer_fsm #(
    .TRAVEL_TICKS(4),
    .HOLD_TICKS  (6),
    .WIDTH       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .open_req   (open_req),
    .close_req  (close_req),
    .obstruct   (obstruct),
    .motor_open (motor_open),
    .motor_close(motor_close),
    .door_closed(door_closed),
    .door_open  (door_open),
    .state      (state)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic expect_tr(input logic [1:0] st, input int d, input string name);
    exp_t e;
    e.st = st;
    e.dticks = d;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // One clock with the given inputs applied; returns 1 time unit after the edge.
  task automatic cyc(input logic t, input logic o, input logic c, input logic ob);
    tick = t;
    open_req = o;
    close_req = c;
    obstruct = ob;
    @(posedge clk);
    #1;
    tick = 1'b0;
    open_req = 1'b0;
    close_req = 1'b0;
  endtask

  task automatic run_ticks(input int n, input logic ob);
    for (int i = 0; i < n; i++) begin
      repeat (4) cyc(1'b0, 1'b0, 1'b0, ob);
      cyc(1'b1, 1'b0, 1'b0, ob);
    end
    obstruct = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (!rst && tick) ticks_total++;
    end
  end

  // Monitor: every state change must match the head of the expectation queue.
  initial begin
    logic [1:0] prev;
    int         last;
    exp_t       e;
    prev = 2'd0;
    last = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 2'd0;
        last = ticks_total;
      end else begin
        chk("motor_exclusive", int'(motor_open & motor_close), 0);
        if (state != prev) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_transition", int'(state), int'(prev));
          end else begin
            e = exp_q.pop_front();
            chk({e.name, "_state"}, int'(state), int'(e.st));
            chk({e.name, "_ticks"}, ticks_total - last, e.dticks);
            chk({e.name, "_outputs"},
                int'({motor_open, motor_close, door_closed, door_open}),
                int'({e.st == 2'd1, e.st == 2'd3, e.st == 2'd0, e.st == 2'd2}));
          end
          prev = state;
          last = ticks_total;
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", int'(state), 0);
    chk("reset_outputs", int'({motor_open, motor_close, door_closed, door_open}), 2);
    rst = 1'b0;
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Full cycle
    expect_tr(2'd1, 0, "full_opening");
    expect_tr(2'd2, 4, "full_open");
    expect_tr(2'd3, 6, "full_closing");
    expect_tr(2'd0, 4, "full_closed");
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    run_ticks(14, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Reopen after 2 closing ticks
    expect_tr(2'd1, 0, "reo_opening");
    expect_tr(2'd2, 4, "reo_open");
    expect_tr(2'd3, 6, "reo_closing");
    expect_tr(2'd1, 2, "reo_reopen");
    expect_tr(2'd2, 2, "reo_open2");
    expect_tr(2'd3, 6, "reo_closing2");
    expect_tr(2'd0, 4, "reo_closed");
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    run_ticks(12, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    run_ticks(12, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Obstruct held in OPEN across 10 ticks
    expect_tr(2'd1, 0, "obs_opening");
    expect_tr(2'd2, 4, "obs_open");
    expect_tr(2'd3, 16, "obs_closing");
    expect_tr(2'd0, 4, "obs_closed");
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    run_ticks(4, 1'b0);
    run_ticks(10, 1'b1);
    run_ticks(10, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Close button, masked then honoured
    expect_tr(2'd1, 0, "btn_opening");
    expect_tr(2'd2, 4, "btn_open");
    expect_tr(2'd3, 2, "btn_closing");
    expect_tr(2'd0, 4, "btn_closed");
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    run_ticks(6, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("close_masked_by_obstruct", int'(state), 2);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("close_latency", int'(state), 3);
    run_ticks(4, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Simultaneous inputs
    expect_tr(2'd1, 0, "sim_opening");
    expect_tr(2'd2, 4, "sim_open");
    expect_tr(2'd3, 11, "sim_closing");
    expect_tr(2'd1, 2, "sim_reopen");
    expect_tr(2'd2, 1, "sim_open2");
    expect_tr(2'd3, 6, "sim_closing2");
    expect_tr(2'd0, 4, "sim_closed");
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    run_ticks(9, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("open_beats_close", int'(state), 2);
    run_ticks(7, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("tick_obstruct_reopen", int'(state), 1);
    run_ticks(11, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-opening
    expect_tr(2'd1, 0, "rst_opening");
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    run_ticks(2, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_motor_open", int'(motor_open), 0);
    chk("async_rst_door_closed", int'(door_closed), 1);
    chk("async_rst_state", int'(state), 0);
    #5;
    rst = 1'b0;
    run_ticks(3, 1'b0);
    chk("post_rst_tick_ignored", int'(state), 0);
    chk("post_rst_door_closed", int'(door_closed), 1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/door_timer_fsm.md
Name: door_timer_fsm

Overview:
- Door sequencing stage directly downstream of the parametric tick counter.
- Consumes the counter's one-clock wrap strobe as its time base.
- Drives the door open/close motor enables, tracks door position in ticks, and times the open-hold interval.
- Reports door status to the car-motion logic, which may move the car only while door_closed=1.

Parameters:
TRAVEL_TICKS, 4, ticks for a full open or a full close stroke (>=1)
HOLD_TICKS, 6, ticks the door stays fully open before auto-close (>=1)
WIDTH, 8, width of the position and hold counters; must hold max(TRAVEL_TICKS, HOLD_TICKS)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
tick  in  1  one-clk strobe from upstream tick counter; time base
open_req  in  1  one-clk pulse: car arrived at floor, or open button pressed
close_req  in  1  one-clk pulse: close button pressed
obstruct  in  1  level: door-edge sensor blocked
motor_open  out  1  open motor enable
motor_close  out  1  close motor enable
door_closed  out  1  door fully closed; car motion permitted
door_open  out  1  door fully open
state  out  2  debug: 0 CLOSED, 1 OPENING, 2 OPEN, 3 CLOSING

Behaviour:
- Reset (async, any state, mid-stroke included) forces:
  - state=CLOSED, pos=0, hold_cnt=0
  - motor_open=0, motor_close=0, door_closed=1, door_open=0
- Outputs are Moore, decoded from the registered state only:
  - motor_open = OPENING; motor_close = CLOSING
  - door_closed = CLOSED; door_open = OPEN
- Latency: one clk from the qualifying input edge to the new state and outputs.
- pos: WIDTH-bit, 0 = closed, TRAVEL_TICKS = open. hold_cnt: WIDTH-bit. tick advances counters only in the states noted below.
- CLOSED:
  - open_req -> OPENING.
  - tick, close_req and obstruct are ignored.
- OPENING:
  - On tick: if pos==TRAVEL_TICKS-1, then pos<=TRAVEL_TICKS, hold_cnt<=0, state<=OPEN; else pos++.
  - open_req, close_req and obstruct are ignored (door already opening).
- OPEN:
  - Priority 1, open_req: hold_cnt<=0 (hold restart); stay OPEN.
  - Priority 2, obstruct=1: hold_cnt<=0 every cycle; close_req is ignored.
  - Priority 3, close_req: state<=CLOSING, hold_cnt<=0.
  - Priority 4, tick: if hold_cnt==HOLD_TICKS-1, then state<=CLOSING, hold_cnt<=0; else hold_cnt++.
  - open_req and close_req in the same cycle: open_req wins.
- CLOSING:
  - Priority 1, obstruct=1 or open_req: state<=OPENING, pos unchanged. The reopen therefore takes exactly the ticks already spent closing.
  - Priority 2, tick: if pos==1, then pos<=0, state<=CLOSED; else pos--.
  - A tick in the same cycle as obstruct/open_req is dropped.
  - close_req is ignored.
- Invariants:
  - pos stays within 0..TRAVEL_TICKS.
  - motor_open and motor_close are never both 1.
  - door_closed=1 exactly when pos==0 and state==CLOSED.
  - pos never wraps; hold_cnt never exceeds HOLD_TICKS-1.
- Back-to-back ticks (tick held high) are legal: one count per clk.

Test Plan:
- Full cycle: defaults, tick every 5 clk; open_req pulse in CLOSED:
  - motor_open=1 for exactly 4 ticks, then door_open=1 for 6 ticks.
  - Then motor_close=1 for 4 ticks, then door_closed=1, state=0.
- Reopen: obstruct asserted after 2 CLOSING ticks (pos=2):
  - Next clk state=OPENING.
  - door_open rises on the 2nd subsequent tick.
  - Hold restarts at 0.
- Obstruct hold: obstruct=1 in OPEN across 10 ticks:
  - Stays OPEN, hold_cnt=0 throughout.
  - Release obstruct: CLOSING on the 6th following tick.
- Close button: close_req in OPEN at hold_cnt=2 -> state=CLOSING next clk. Same pulse with obstruct=1 -> stays OPEN.
- Simultaneous inputs: open_req+close_req in the same clk in OPEN at hold_cnt=5 -> stays OPEN, hold_cnt=0, CLOSING after 6 more ticks. tick+obstruct in the same clk in CLOSING at pos=3 -> OPENING with pos=3.
- Reset mid-operation: rst pulse while OPENING at pos=2, asynchronous to clk:
  - Outputs go to their reset values immediately (motor_open=0, door_closed=1).
  - After release, tick alone causes no state change.
